// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - measured-clock input and period/lock/timeout result bundle
interface period_meter_if;
  logic        meas_clk;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  modport master (
    output meas_clk,
    input  period,
    input  period_valid,
    input  locked,
    input  timeout
  );

  modport slave (
    input  meas_clk,
    output period,
    output period_valid,
    output locked,
    output timeout
  );
endinterface

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures meas_clk period in clk_in cycles with lock and stall detection
module period_meter #(
  parameter int unsigned EXPECTED    = 394,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic         clk_in,
  input  logic         reset,
  period_meter_if.slave bus
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam logic [15:0] LO_LIM   = 16'(EXPECTED - TOL);
  localparam logic [15:0] HI_LIM   = 16'(EXPECTED + TOL);
  localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYC);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_STALL   = 2'd2
  } state_t;

  // Synchronizer, edge history and rise detector
  logic          sync1_q, sync2_q, sync3_q;
  logic [1:0]    prime_q;
  logic          armed_q;
  logic          edge_q;

  // Measurement FSM state
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   period_q, period_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;
  logic [MW-1:0] match_q, match_d;

  logic          in_range;

  // Bring meas_clk into clk_in domain and flag each rise once.
  // prime_q marks when sync2_q holds a real sample; armed_q requires a
  // genuine low level first, so a meas_clk already high at reset release
  // is not mistaken for a rising edge.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= bus.meas_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      prime_q <= {prime_q[0], 1'b1};
      if (prime_q[1] && !sync2_q) begin
        armed_q <= 1'b1;
      end
      edge_q  <= sync2_q & ~sync3_q & armed_q;
    end
  end

  assign in_range = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);

  // State and result registers
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      period_q  <= 16'd0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      match_q   <= match_d;
    end
  end

  // Next-state: count cycles between rises, report, track lock and stalls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    match_d   = match_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (edge_q) begin
          state_d = S_MEASURE;
          cnt_d   = 16'd1;
        end
      end

      S_MEASURE: begin
        if (edge_q) begin
          // A rise coinciding with the timeout count still closes the period.
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = 16'd1;
          if (in_range) begin
            if (match_q < LOCK_N) begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
          locked_d = (match_d == LOCK_N);
        end else if (cnt_q == TO_LIM) begin
          state_d   = S_STALL;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          cnt_d     = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_STALL: begin
        timeout_d = 1'b1;
        // The first rise after a stall only restarts the count.
        if (edge_q) begin
          state_d   = S_MEASURE;
          cnt_d     = 16'd1;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - scoreboard bench for period_meter with rise-to-rise reference model
module tb_period_meter;

  localparam int EXPECTED    = 394;
  localparam int TOL         = 2;
  localparam int LOCK_COUNT  = 4;
  localparam int TIMEOUT_CYC = 4095;

  typedef struct {
    int per;
    bit lck;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   cyc    = 0;

  period_meter_if bus ();

  period_meter dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  // Reference model: meas_clk rise history in clk_in cycles
  int model_active = 0;
  int last_rise    = 0;
  int match        = 0;

  // Monitor bookkeeping
  int last_valid_cyc    = 0;
  int last_valid_period = 0;
  int timeout_events    = 0;
  bit prev_valid        = 1'b0;
  bit prev_timeout      = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    model_active = 0;
    match        = 0;
    last_rise    = cyc;
  endtask

  // A rise closes the interval since the previous rise. The very first rise
  // (after reset) and the first rise after a stall only start a new interval.
  task automatic model_rise();
    int   gap;
    bit   in_rng;
    exp_t e;
    gap       = cyc - last_rise;
    last_rise = cyc;
    if (!model_active) begin
      model_active = 1;
    end else if (gap > TIMEOUT_CYC) begin
      match = 0;
    end else begin
      in_rng = (gap >= EXPECTED - TOL) && (gap <= EXPECTED + TOL);
      if (in_rng) begin
        if (match < LOCK_COUNT) match++;
      end else begin
        match = 0;
      end
      e.per = gap;
      e.lck = (match == LOCK_COUNT);
      expq.push_back(e);
    end
  endtask

  task automatic rise(input int hi, input int lo);
    bus.meas_clk = 1'b1;
    model_rise();
    repeat (hi) @(negedge clk_in);
    bus.meas_clk = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_period"},  int'(bus.period),       0);
    check({tag, "_valid"},   int'(bus.period_valid), 0);
    check({tag, "_locked"},  int'(bus.locked),       0);
    check({tag, "_timeout"}, int'(bus.timeout),      0);
  endtask

  // Monitor: pop the scoreboard on every period_valid, watch timeout onset
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        if (bus.period_valid) begin
          check("valid_not_back_to_back", int'(prev_valid), 0);
          if (expq.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = expq.pop_front();
            check("period", int'(bus.period), e.per);
            check("locked", int'(bus.locked), int'(e.lck));
          end
          last_valid_cyc    = cyc;
          last_valid_period = int'(bus.period);
        end
        if (bus.timeout && !prev_timeout) begin
          timeout_events++;
          check("timeout_delay", cyc - last_valid_cyc, TIMEOUT_CYC);
          check("timeout_locked", int'(bus.locked), 0);
          check("timeout_period_kept", int'(bus.period), last_valid_period);
        end
        prev_valid   = bus.period_valid;
        prev_timeout = bus.timeout;
      end else begin
        prev_valid   = 1'b0;
        prev_timeout = 1'b0;
      end
    end
  end

  initial begin
    int per;
    int hi;
    int waited;

    // meas_clk high through reset release must not count as a rise
    bus.meas_clk = 1'b1;
    reset        = 1'b0;
    repeat (3) @(negedge clk_in);
    check_outputs_zero("reset");
    reset = 1'b1;
    model_reset();
    repeat (20) @(negedge clk_in);
    bus.meas_clk = 1'b0;
    repeat (50) @(negedge clk_in);

    // Nominal 394-cycle clock: first rise starts, lock on 4th report
    repeat (6) rise(197, 197);

    // One 400-cycle period breaks lock, four nominal periods restore it
    rise(200, 200);
    repeat (4) rise(197, 197);

    // Tolerance limits: 392/396 in range, 391/397 clear lock
    rise(196, 196);
    rise(198, 198);
    repeat (2) rise(197, 197);
    rise(195, 196);
    repeat (4) rise(197, 197);
    rise(198, 199);
    rise(197, 197);

    // Stall: long low, recovery rise gives no report, the next one does
    rise(197, 197);
    rise(197, 5000);
    check("timeout_seen", timeout_events, 1);
    rise(197, 197);
    check("timeout_cleared", int'(bus.timeout), 0);
    rise(197, 197);

    // Reset about 200 cycles into a period discards it
    bus.meas_clk = 1'b1;
    model_rise();
    repeat (197) @(negedge clk_in);
    bus.meas_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check_outputs_zero("midreset");
    reset = 1'b1;
    model_reset();
    repeat (100) @(negedge clk_in);
    repeat (3) rise(197, 197);

    // +/-1 cycle jitter with random duty cycle
    repeat (30) begin
      per = EXPECTED + int'($urandom_range(0, 2)) - 1;
      hi  = int'($urandom_range(100, 290));
      rise(hi, per - hi);
    end

    // Wider random periods to exercise lock gain and loss
    repeat (20) begin
      per = int'($urandom_range(EXPECTED - 9, EXPECTED + 9));
      hi  = int'($urandom_range(50, 300));
      rise(hi, per - hi);
    end

    // Closing rise reports the last interval; drain the scoreboard
    rise(197, 20);
    waited = 0;
    while (expq.size() != 0 && waited < 50) begin
      @(negedge clk_in);
      waited++;
    end
    check("scoreboard_drained", expq.size(), 0);
    check("timeout_events_total", timeout_events, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
